// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, req/ack instruction-memory port, small in-order
// instruction queue toward decode, and branch redirect with in-flight squash.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   output logic [4:0]  inst_opcode6_2
);

   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_KILL} state_e;

   state_e          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [31:0]     req_addr_q, req_addr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [31:0]     q_pc_q   [QDEPTH];
   logic [31:0]     q_inst_q [QDEPTH];

   logic issue;
   logic push;
   logic pop;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (issue && !imem_ack) state_d = S_WAIT;
         S_WAIT: begin
            if (imem_ack)            state_d = S_IDLE;
            else if (redirect_valid) state_d = S_KILL;
         end
         S_KILL: if (imem_ack) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Memory-port outputs; push only for an unsquashed returning word
   always_comb begin
      issue     = 1'b0;
      push      = 1'b0;
      imem_req  = 1'b0;
      imem_addr = pc_q;
      case (state_q)
         S_IDLE: begin
            issue    = rst_n && (count_q < CW'(QDEPTH)) && !redirect_valid;
            imem_req = issue;
            push     = issue && imem_ack;
         end
         S_WAIT: begin
            imem_req  = rst_n;
            imem_addr = req_addr_q;
            push      = imem_ack && !redirect_valid;
         end
         S_KILL: begin
            imem_req  = rst_n;
            imem_addr = req_addr_q;
         end
         default: ;
      endcase
   end

   assign pop = inst_valid && inst_ready;

   // Datapath next-state; redirect overrides push, pop and pc increment
   always_comb begin
      pc_d       = pc_q;
      req_addr_d = issue ? pc_q : req_addr_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (redirect_valid) begin
         pc_d     = redirect_pc & ~32'h3;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            pc_d     = pc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         req_addr_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Queue storage
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(QDEPTH); i++) begin
            q_pc_q[i]   <= '0;
            q_inst_q[i] <= '0;
         end
      end else if (push) begin
         q_pc_q[wr_ptr_q]   <= imem_addr;
         q_inst_q[wr_ptr_q] <= imem_rdata;
      end
   end

   assign inst_valid     = (count_q != '0);
   assign inst_out       = q_inst_q[rd_ptr_q];
   assign inst_pc        = q_pc_q[rd_ptr_q];
   assign inst_opcode6_2 = inst_valid ? inst_out[6:2] : 5'b11111;

endmodule
